arb_requester: RTL and testbench

Client-side agent for the two-requester arbiter (`req`/`gnt` handshake). It sits between a local job source and one requester port of the arbiter. Queued jobs are turned into request/grant transactions. Each job produces a burst of 1..2^LEN_W beats while the grant is held. The request is then released for one cycle so the arbiter can rotate.

---
 rtl/arb_requester.sv | 260 ++++++++++++++++++++++++++
 tb/tb_arb_requester.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_requester.sv
// -----------------------------------------------------------------------------
// arb_requester
//
// Client-side agent for one requester port of a two-requester arbiter. Jobs
// offered on the job_* interface are held in a small FIFO. Each queued job
// becomes one req/gnt transaction. While the grant is held, the agent emits
// a burst of job_len+1 beats. The request is then dropped for one cycle so
// the arbiter can rotate to the other port.
//
// Optional feature (compile-time macro REQ_TIMEOUT_EN):
//   When the macro is defined, a wait counter bounds how long req may stay
//   high without a grant. Once the bound is hit, the head job is dropped and
//   err is pulsed. When the macro is undefined, no counter exists and REQ
//   waits for gnt indefinitely.
//
// Parameters:
//   LEN_W    width of job_len and beat_idx
//   DEPTH    job queue depth in entries (power of 2, >= 2)
//   TIMEOUT  max cycles req stays high without gnt (only with REQ_TIMEOUT_EN)
//
// Ports:
//   clock       in   single clock, all logic on the rising edge
//   reset       in   synchronous, active-low reset
//   job_valid   in   a job is offered this cycle
//   job_len     in   burst length minus one (0 -> 1 beat)
//   job_ready   out  queue can accept a job (not full)
//   gnt         in   grant from the arbiter for this port
//   req         out  request to the arbiter
//   beat_valid  out  one transfer beat this cycle
//   beat_idx    out  0-based index of the current beat
//   done        out  one-cycle pulse, burst completed normally
//   err         out  one-cycle pulse, burst aborted (preempted or timed out)
//   busy        out  FSM not idle or queue not empty
// -----------------------------------------------------------------------------
module arb_requester #(
    parameter int LEN_W   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    output logic             job_ready,
    input  logic             gnt,
    output logic             req,
    output logic             beat_valid,
    output logic [LEN_W-1:0] beat_idx,
    output logic             done,
    output logic             err,
    output logic             busy
);

    // -------------------------------------------------------------------------
    // Local types and constants
    // -------------------------------------------------------------------------
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_idx_q, beat_idx_d;
    // Exit cause carried into RELEASE: 1 = aborted (err), 0 = completed (done).
    logic               abort_q, abort_d;

    logic [LEN_W-1:0]   mem_q [DEPTH];
    logic [LEN_W-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               push;
    logic               pop;
    logic               q_empty;
    logic               timeout_hit;

    // -------------------------------------------------------------------------
    // Queue status. job_ready depends only on the registered count, so no
    // input reaches an output combinationally.
    // -------------------------------------------------------------------------
    assign q_empty   = (count_q == '0);
    assign job_ready = (count_q != FULL_CNT);
    assign push      = job_valid && job_ready;

    // -------------------------------------------------------------------------
    // Optional REQ wait counter
    // -------------------------------------------------------------------------
`ifdef REQ_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;

    // Fires in the TIMEOUT-th REQ cycle; the FSM lets a grant override it.
    assign timeout_hit = (state_q == ST_REQ) && (wait_q == WAIT_LAST);

    always_comb begin
        wait_d = wait_q;
        // Held at zero outside REQ so every REQ entry starts a fresh count.
        if (state_q != ST_REQ) begin
            wait_d = '0;
        end else if (!gnt) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign timeout_hit = 1'b0;

    // TIMEOUT has no effect in this build; fold it into a sink so the
    // parameter is still referenced.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT >= 1);
`endif

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        beat_idx_d = beat_idx_q;
        abort_d    = abort_q;
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                // The grant is checked first so it wins over a timeout in
                // the same cycle.
                if (gnt) begin
                    pop        = 1'b1;
                    len_d      = mem_q[rd_ptr_q];
                    beat_idx_d = '0;
                    state_d    = ST_XFER;
                end else if (timeout_hit) begin
                    pop     = 1'b1;
                    abort_d = 1'b1;
                    state_d = ST_RELEASE;
                end
            end

            ST_XFER: begin
                if (!gnt) begin
                    // Preempted: the remaining beats are dropped.
                    abort_d = 1'b1;
                    state_d = ST_RELEASE;
                end else if (beat_idx_q == len_q) begin
                    abort_d = 1'b0;
                    state_d = ST_RELEASE;
                end else begin
                    beat_idx_d = beat_idx_q + 1'b1;
                end
            end

            ST_RELEASE: begin
                // One cycle with req low so the arbiter can rotate.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Queue next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = job_len;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        // A pop only happens when leaving REQ, which is entered with a
        // non-empty queue, so the queue cannot underflow.
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            beat_idx_q <= '0;
            abort_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            beat_idx_q <= beat_idx_d;
            abort_q    <= abort_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: the queue storage is deliberately not reset; clearing count and
    // pointers empties the queue, and an entry is only read after a write.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // -------------------------------------------------------------------------
    // Moore outputs, decoded from registered state only
    // -------------------------------------------------------------------------
    assign req        = (state_q == ST_REQ) || (state_q == ST_XFER);
    assign beat_valid = (state_q == ST_XFER);
    assign beat_idx   = beat_valid ? beat_idx_q : '0;
    assign done       = (state_q == ST_RELEASE) && !abort_q;
    assign err        = (state_q == ST_RELEASE) && abort_q;
    assign busy       = (state_q != ST_IDLE) || !q_empty;

endmodule

// File: tb/tb_arb_requester.sv
// -----------------------------------------------------------------------------
// tb_arb_requester
//
// Directed bench for arb_requester with default parameters (LEN_W=4, DEPTH=4,
// TIMEOUT=15). Each scenario is a table of per-cycle inputs; after the clock
// edge, the packed output vector
//   {req, beat_valid, beat_idx[3:0], done, err, busy, job_ready}
// is compared against the hand-computed expectation for that row.
// Build with +define+REQ_TIMEOUT_EN to exercise the timeout scenario; without
// it, the bench checks that REQ waits indefinitely instead.
// -----------------------------------------------------------------------------
module tb_arb_requester;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clock;
    logic       reset;
    logic       job_valid;
    logic [3:0] job_len;
    logic       job_ready;
    logic       gnt;
    logic       req;
    logic       beat_valid;
    logic [3:0] beat_idx;
    logic       done;
    logic       err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       jv;
        logic [3:0] jl;
        logic       g;
        logic [9:0] e;
    } vec_t;

    arb_requester #(
        .LEN_W   (4),
        .DEPTH   (4),
        .TIMEOUT (15)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .job_valid  (job_valid),
        .job_len    (job_len),
        .job_ready  (job_ready),
        .gnt        (gnt),
        .req        (req),
        .beat_valid (beat_valid),
        .beat_idx   (beat_idx),
        .done       (done),
        .err        (err),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [9:0] ev(input logic r, input logic bv,
                                      input logic [3:0] idx, input logic d,
                                      input logic e, input logic b,
                                      input logic rdy);
        return {r, bv, idx, d, e, b, rdy};
    endfunction

    function automatic logic [9:0] obs();
        return {req, beat_valid, beat_idx, done, err, busy, job_ready};
    endfunction

    function automatic vec_t mk(input logic jv, input logic [3:0] jl,
                                input logic g, input logic [9:0] e);
        vec_t v;
        v.jv = jv;
        v.jl = jl;
        v.g  = g;
        v.e  = e;
        return v;
    endfunction

    // -------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0; job_valid = 1'b1; job_len = 4'd3; gnt = 1'b1;
        tick();
        tick();
        total++;
        if (obs() !== ev(L, L, 4'd0, L, L, L, H)) begin
            bad++;
            $display("FAIL reset_held: got %b expected %b", obs(), ev(L, L, 4'd0, L, L, L, H));
        end
        reset = 1'b1; job_valid = 1'b0; gnt = 1'b0;
        tick();
        total++;
        if (obs() !== ev(L, L, 4'd0, L, L, L, H)) begin
            bad++;
            $display("FAIL reset_release: got %b expected %b", obs(), ev(L, L, 4'd0, L, L, L, H));
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_single_job();
        vec_t v[$];
        v.push_back(mk(H, 4'd2, L, ev(L, L, 4'd0, L, L, H, H)));  // pushed, IDLE
        v.push_back(mk(L, 4'd0, L, ev(H, L, 4'd0, L, L, H, H)));  // REQ
        v.push_back(mk(L, 4'd0, L, ev(H, L, 4'd0, L, L, H, H)));  // REQ, no gnt yet
        v.push_back(mk(L, 4'd0, H, ev(H, H, 4'd0, L, L, H, H)));  // beat 0
        v.push_back(mk(L, 4'd0, H, ev(H, H, 4'd1, L, L, H, H)));  // beat 1
        v.push_back(mk(L, 4'd0, H, ev(H, H, 4'd2, L, L, H, H)));  // beat 2
        v.push_back(mk(L, 4'd0, H, ev(L, L, 4'd0, H, L, H, H)));  // RELEASE, done
        v.push_back(mk(L, 4'd0, L, ev(L, L, 4'd0, L, L, L, H)));  // IDLE
        v.push_back(mk(L, 4'd0, L, ev(L, L, 4'd0, L, L, L, H)));  // stays IDLE
        foreach (v[i]) begin
            job_valid = v[i].jv; job_len = v[i].jl; gnt = v[i].g;
            tick();
            total++;
            if (obs() !== v[i].e) begin
                bad++;
                $display("FAIL single_job row %0d: got %b expected %b", i, obs(), v[i].e);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_queue_full();
        vec_t v[$];
        v.push_back(mk(H, 4'd0, L, ev(L, L, 4'd0, L, L, H, H)));  // count 1
        v.push_back(mk(H, 4'd1, L, ev(H, L, 4'd0, L, L, H, H)));  // count 2, REQ
        v.push_back(mk(H, 4'd2, L, ev(H, L, 4'd0, L, L, H, H)));  // count 3
        v.push_back(mk(H, 4'd3, L, ev(H, L, 4'd0, L, L, H, L)));  // count 4, full
        v.push_back(mk(H, 4'd4, L, ev(H, L, 4'd0, L, L, H, L)));  // 5th refused
        v.push_back(mk(H, 4'd4, L, ev(H, L, 4'd0, L, L, H, L)));  // still refused
        v.push_back(mk(H, 4'd4, H, ev(H, H, 4'd0, L, L, H, H)));  // pop job len 0
        v.push_back(mk(H, 4'd4, H, ev(L, L, 4'd0, H, L, H, L)));  // 5th accepted, done
        v.push_back(mk(L, 4'd0, L, ev(L, L, 4'd0, L, L, H, L)));  // IDLE, full
        v.push_back(mk(L, 4'd0, L, ev(H, L, 4'd0, L, L, H, L)));  // REQ job len 1
        v.push_back(mk(L, 4'd0, H, ev(H, H, 4'd0, L, L, H, H)));  // beat 0
        v.push_back(mk(L, 4'd0, H, ev(H, H, 4'd1, L, L, H, H)));  // beat 1
        v.push_back(mk(L, 4'd0, H, ev(L, L, 4'd0, H, L, H, H)));  // done
        foreach (v[i]) begin
            job_valid = v[i].jv; job_len = v[i].jl; gnt = v[i].g;
            tick();
            total++;
            if (obs() !== v[i].e) begin
                bad++;
                $display("FAIL queue_full row %0d: got %b expected %b", i, obs(), v[i].e);
            end
        end
        // Three jobs remain queued; reset must discard them.
        reset = 1'b0; job_valid = 1'b0; gnt = 1'b0;
        tick();
        total++;
        if (obs() !== ev(L, L, 4'd0, L, L, L, H)) begin
            bad++;
            $display("FAIL queue_flush_reset: got %b expected %b", obs(), ev(L, L, 4'd0, L, L, L, H));
        end
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (obs() !== ev(L, L, 4'd0, L, L, L, H)) begin
            bad++;
            $display("FAIL queue_flush_idle: got %b expected %b", obs(), ev(L, L, 4'd0, L, L, L, H));
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_preemption();
        vec_t v[$];
        v.push_back(mk(H, 4'd7, L, ev(L, L, 4'd0, L, L, H, H)));  // job A len 7
        v.push_back(mk(H, 4'd1, L, ev(H, L, 4'd0, L, L, H, H)));  // job B len 1, REQ
        v.push_back(mk(L, 4'd0, H, ev(H, H, 4'd0, L, L, H, H)));
        v.push_back(mk(L, 4'd0, H, ev(H, H, 4'd1, L, L, H, H)));
        v.push_back(mk(L, 4'd0, H, ev(H, H, 4'd2, L, L, H, H)));
        v.push_back(mk(L, 4'd0, H, ev(H, H, 4'd3, L, L, H, H)));  // beat 3
        v.push_back(mk(L, 4'd0, L, ev(L, L, 4'd0, L, H, H, H)));  // preempted, err
        v.push_back(mk(L, 4'd0, L, ev(L, L, 4'd0, L, L, H, H)));  // IDLE, B queued
        v.push_back(mk(L, 4'd0, L, ev(H, L, 4'd0, L, L, H, H)));  // B re-requests
        v.push_back(mk(L, 4'd0, H, ev(H, H, 4'd0, L, L, H, H)));
        v.push_back(mk(L, 4'd0, H, ev(H, H, 4'd1, L, L, H, H)));
        v.push_back(mk(L, 4'd0, H, ev(L, L, 4'd0, H, L, H, H)));  // done
        v.push_back(mk(L, 4'd0, L, ev(L, L, 4'd0, L, L, L, H)));  // idle, empty
        foreach (v[i]) begin
            job_valid = v[i].jv; job_len = v[i].jl; gnt = v[i].g;
            tick();
            total++;
            if (obs() !== v[i].e) begin
                bad++;
                $display("FAIL preemption row %0d: got %b expected %b", i, obs(), v[i].e);
            end
        end
    endtask

`ifdef REQ_TIMEOUT_EN
    // -------------------------------------------------------------------------
    task automatic test_timeout();
        vec_t v[$];
        // Part 1: no grant at all -> 15 req cycles, err, job discarded.
        v.push_back(mk(H, 4'd0, L, ev(L, L, 4'd0, L, L, H, H)));
        for (int k = 1; k <= 15; k++) begin
            v.push_back(mk(L, 4'd0, L, ev(H, L, 4'd0, L, L, H, H)));
        end
        v.push_back(mk(L, 4'd0, L, ev(L, L, 4'd0, L, H, H, H)));  // timeout err
        v.push_back(mk(L, 4'd0, L, ev(L, L, 4'd0, L, L, L, H)));  // discarded
        v.push_back(mk(L, 4'd0, L, ev(L, L, 4'd0, L, L, L, H)));  // no re-request
        // Part 2: grant arrives in the 15th req cycle -> grant wins.
        v.push_back(mk(H, 4'd1, L, ev(L, L, 4'd0, L, L, H, H)));
        for (int k = 1; k <= 15; k++) begin
            v.push_back(mk(L, 4'd0, L, ev(H, L, 4'd0, L, L, H, H)));
        end
        v.push_back(mk(L, 4'd0, H, ev(H, H, 4'd0, L, L, H, H)));  // beat 0, no err
        v.push_back(mk(L, 4'd0, H, ev(H, H, 4'd1, L, L, H, H)));
        v.push_back(mk(L, 4'd0, H, ev(L, L, 4'd0, H, L, H, H)));  // done
        v.push_back(mk(L, 4'd0, L, ev(L, L, 4'd0, L, L, L, H)));
        foreach (v[i]) begin
            job_valid = v[i].jv; job_len = v[i].jl; gnt = v[i].g;
            tick();
            total++;
            if (obs() !== v[i].e) begin
                bad++;
                $display("FAIL timeout row %0d: got %b expected %b", i, obs(), v[i].e);
            end
        end
    endtask
`else
    // -------------------------------------------------------------------------
    task automatic test_no_timeout();
        vec_t v[$];
        v.push_back(mk(H, 4'd0, L, ev(L, L, 4'd0, L, L, H, H)));
        for (int k = 1; k <= 40; k++) begin
            v.push_back(mk(L, 4'd0, L, ev(H, L, 4'd0, L, L, H, H)));
        end
        v.push_back(mk(L, 4'd0, H, ev(H, H, 4'd0, L, L, H, H)));
        v.push_back(mk(L, 4'd0, H, ev(L, L, 4'd0, H, L, H, H)));
        v.push_back(mk(L, 4'd0, L, ev(L, L, 4'd0, L, L, L, H)));
        foreach (v[i]) begin
            job_valid = v[i].jv; job_len = v[i].jl; gnt = v[i].g;
            tick();
            total++;
            if (obs() !== v[i].e) begin
                bad++;
                $display("FAIL no_timeout row %0d: got %b expected %b", i, obs(), v[i].e);
            end
        end
    endtask
`endif

    // -------------------------------------------------------------------------
    task automatic test_reset_mid_burst();
        vec_t v[$];
        v.push_back(mk(H, 4'd15, L, ev(L, L, 4'd0, L, L, H, H)));
        v.push_back(mk(H, 4'd3,  L, ev(H, L, 4'd0, L, L, H, H)));  // 2nd job queued
        v.push_back(mk(L, 4'd0,  H, ev(H, H, 4'd0, L, L, H, H)));
        v.push_back(mk(L, 4'd0,  H, ev(H, H, 4'd1, L, L, H, H)));
        v.push_back(mk(L, 4'd0,  H, ev(H, H, 4'd2, L, L, H, H)));  // beat 2
        foreach (v[i]) begin
            job_valid = v[i].jv; job_len = v[i].jl; gnt = v[i].g;
            tick();
            total++;
            if (obs() !== v[i].e) begin
                bad++;
                $display("FAIL reset_mid row %0d: got %b expected %b", i, obs(), v[i].e);
            end
        end
        reset = 1'b0; gnt = 1'b1;
        tick();
        total++;
        if (obs() !== ev(L, L, 4'd0, L, L, L, H)) begin
            bad++;
            $display("FAIL reset_mid_edge: got %b expected %b", obs(), ev(L, L, 4'd0, L, L, L, H));
        end
        reset = 1'b1; gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (obs() !== ev(L, L, 4'd0, L, L, L, H)) begin
                bad++;
                $display("FAIL reset_mid_after cyc %0d: got %b expected %b", k, obs(), ev(L, L, 4'd0, L, L, L, H));
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_max_len();
        vec_t v[$];
        v.push_back(mk(H, 4'd15, L, ev(L, L, 4'd0, L, L, H, H)));
        v.push_back(mk(L, 4'd0,  L, ev(H, L, 4'd0, L, L, H, H)));
        for (int k = 0; k < 16; k++) begin
            v.push_back(mk(L, 4'd0, H, ev(H, H, 4'(k), L, L, H, H)));
        end
        v.push_back(mk(L, 4'd0, H, ev(L, L, 4'd0, H, L, H, H)));  // single done
        v.push_back(mk(L, 4'd0, H, ev(L, L, 4'd0, L, L, L, H)));  // no 2nd done
        v.push_back(mk(L, 4'd0, L, ev(L, L, 4'd0, L, L, L, H)));
        foreach (v[i]) begin
            job_valid = v[i].jv; job_len = v[i].jl; gnt = v[i].g;
            tick();
            total++;
            if (obs() !== v[i].e) begin
                bad++;
                $display("FAIL max_len row %0d: got %b expected %b", i, obs(), v[i].e);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        reset     = 1'b0;
        job_valid = 1'b0;
        job_len   = 4'd0;
        gnt       = 1'b0;

        test_reset();
        test_single_job();
        test_queue_full();
        test_preemption();
`ifdef REQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_burst();
        test_max_len();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
